// File: rtl/mac_seq_pkg.sv
// Shared types and default timing constants for the MAC link bring-up sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    RESET_GT,
    WAIT_GT,
    WAIT_BLK,
    STABLE,
    ENABLE,
    READY
  } seq_state_e;

  localparam int unsigned DEF_DATA_W        = 64;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_RESET_CYCLES  = 64;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 2_000_000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_CNT_W         = 24;
  localparam int unsigned RETRY_W           = 8;
  localparam int unsigned DROP_W            = 16;

endpackage

// File: rtl/mac_tx_gate.sv
// Frame-boundary gate on the user TX stream: frames pass only if the link was
// ready at their first beat; rejected frames are swallowed and counted.
module mac_tx_gate
  import mac_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mac_ready_i,
  input  logic [DATA_W-1:0]   s_axis_tdata_i,
  input  logic [DATA_W/8-1:0] s_axis_tkeep_i,
  input  logic                s_axis_tvalid_i,
  input  logic                s_axis_tlast_i,
  output logic                s_axis_tready_o,
  output logic [DATA_W-1:0]   m_axis_tdata_o,
  output logic [DATA_W/8-1:0] m_axis_tkeep_o,
  output logic                m_axis_tvalid_o,
  output logic                m_axis_tlast_o,
  input  logic                m_axis_tready_i,
  output logic [DROP_W-1:0]   drop_cnt_o
);

  logic              in_frame_q, in_frame_d;
  logic              pass_q, pass_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              pass_c;
  logic              accept_c;

  // Until a frame's first beat is seen, the live ready state decides.
  assign pass_c   = in_frame_q ? pass_q : mac_ready_i;
  assign accept_c = s_axis_tvalid_i & s_axis_tready_o;

  always_comb begin
    m_axis_tdata_o  = s_axis_tdata_i;
    m_axis_tkeep_o  = s_axis_tkeep_i;
    m_axis_tlast_o  = s_axis_tlast_i;
    m_axis_tvalid_o = pass_c & s_axis_tvalid_i;
    s_axis_tready_o = pass_c ? m_axis_tready_i : 1'b1;
  end

  // Decision is latched on the first valid beat, even if stalled, so tvalid
  // towards the MAC is never withdrawn mid-handshake.
  always_comb begin
    in_frame_d = in_frame_q;
    pass_d     = pass_q;
    drop_d     = drop_q;
    if (accept_c && s_axis_tlast_i) begin
      in_frame_d = 1'b0;
      if (!pass_c) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end else if (s_axis_tvalid_i && !in_frame_q) begin
      in_frame_d = 1'b1;
      pass_d     = pass_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame_q <= 1'b0;
      pass_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      in_frame_q <= in_frame_d;
      pass_q     <= pass_d;
      drop_q     <= drop_d;
    end
  end

  assign drop_cnt_o = drop_q;

endmodule

// File: rtl/mac_link_sequencer.sv
// QSFP 25GE MAC/GT bring-up: GT reset, lock waits, debounce, MAC enable, and
// the qualified mac_ready used to gate the user TX stream.
module mac_link_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_gt_locked,
  input  logic                rx_block_lock,
  output logic                gt_reset,
  output logic                ctl_tx_enable,
  output logic                ctl_rx_enable,
  output logic                mac_ready,
  output logic [RETRY_W-1:0]  retry_cnt,
  output logic [DROP_W-1:0]   drop_cnt,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready
);

  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] gt_sync_q;
  logic [SYNC_STAGES-1:0] blk_sync_q;
  logic                   gt_l;
  logic                   blk_l;

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       timer_q, timer_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic                   retry_inc;
  logic                   gt_reset_q, gt_reset_d;
  logic                   ctl_en_q, ctl_en_d;
  logic                   ready_q, ready_d;

  // Lock inputs are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_sync_q  <= '0;
      blk_sync_q <= '0;
    end else begin
      gt_sync_q  <= {gt_sync_q[SYNC_STAGES-2:0], rx_gt_locked};
      blk_sync_q <= {blk_sync_q[SYNC_STAGES-2:0], rx_block_lock};
    end
  end

  assign gt_l  = gt_sync_q[SYNC_STAGES-1];
  assign blk_l = blk_sync_q[SYNC_STAGES-1];

  // Lock loss outranks timer expiry; GT loss outranks block-lock loss.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    case (state_q)
      RESET_GT: begin
        if (timer_q == RESET_LAST) state_d = WAIT_GT;
      end
      WAIT_GT: begin
        if (gt_l) begin
          state_d = WAIT_BLK;
        end else if (timer_q == TMO_LAST) begin
          state_d   = RESET_GT;
          retry_inc = 1'b1;
        end
      end
      WAIT_BLK: begin
        if (!gt_l) begin
          state_d = WAIT_GT;
        end else if (blk_l) begin
          state_d = STABLE;
        end else if (timer_q == TMO_LAST) begin
          state_d   = RESET_GT;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!gt_l)                       state_d = WAIT_GT;
        else if (!blk_l)                 state_d = WAIT_BLK;
        else if (timer_q == STABLE_LAST) state_d = ENABLE;
      end
      ENABLE: begin
        state_d = READY;
      end
      READY: begin
        if (!gt_l)       state_d = WAIT_GT;
        else if (!blk_l) state_d = WAIT_BLK;
      end
      default: begin
        state_d = RESET_GT;
      end
    endcase

    timer_d    = (state_d != state_q) ? '0 : timer_q + CNT_W'(1);
    retry_d    = (retry_inc && (retry_q != '1)) ? retry_q + RETRY_W'(1) : retry_q;
    gt_reset_d = (state_d == RESET_GT);
    ctl_en_d   = (state_d == ENABLE) || (state_d == READY);
    ready_d    = (state_d == READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_GT;
      timer_q    <= '0;
      retry_q    <= '0;
      gt_reset_q <= 1'b1;
      ctl_en_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      gt_reset_q <= gt_reset_d;
      ctl_en_q   <= ctl_en_d;
      ready_q    <= ready_d;
    end
  end

  assign gt_reset      = gt_reset_q;
  assign ctl_tx_enable = ctl_en_q;
  assign ctl_rx_enable = ctl_en_q;
  assign mac_ready     = ready_q;
  assign retry_cnt     = retry_q;

  mac_tx_gate #(
    .DATA_W (DATA_W)
  ) u_tx_gate (
    .clk             (clk),
    .rst_n           (rst_n),
    .mac_ready_i     (ready_q),
    .s_axis_tdata_i  (s_axis_tdata),
    .s_axis_tkeep_i  (s_axis_tkeep),
    .s_axis_tvalid_i (s_axis_tvalid),
    .s_axis_tlast_i  (s_axis_tlast),
    .s_axis_tready_o (s_axis_tready),
    .m_axis_tdata_o  (m_axis_tdata),
    .m_axis_tkeep_o  (m_axis_tkeep),
    .m_axis_tvalid_o (m_axis_tvalid),
    .m_axis_tlast_o  (m_axis_tlast),
    .m_axis_tready_i (m_axis_tready),
    .drop_cnt_o      (drop_cnt)
  );

endmodule

// File: tb/tb_mac_link_sequencer.sv
// Directed bench for mac_link_sequencer with shortened timeouts; a second
// instance with tiny timing exercises retry counter saturation.
module tb_mac_link_sequencer;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int RC = 16;
  localparam int LT = 500;
  localparam int SC = 32;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_gt_locked, rx_block_lock;
  logic          gt_reset, ctl_tx_enable, ctl_rx_enable, mac_ready;
  logic [7:0]    retry_cnt;
  logic [15:0]   drop_cnt;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s_axis_tkeep, m_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;

  logic          sat_zero;
  logic [DW-1:0] sat_data;
  logic [KW-1:0] sat_keep;
  logic          sat_gt_reset, sat_tx_en, sat_rx_en, sat_ready;
  logic [7:0]    sat_retry;
  logic [15:0]   sat_drop;
  logic          sat_s_tready, sat_m_tvalid, sat_m_tlast;
  logic [DW-1:0] sat_m_tdata;
  logic [KW-1:0] sat_m_tkeep;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] got_data[$];
  logic [KW-1:0] got_keep[$];
  logic          got_last[$];
  int mv_seen, s_ready_lo, stall_ready_hi, stall_valid_lo;

  always #5 clk = ~clk;

  mac_link_sequencer #(
    .DATA_W(DW), .SYNC_STAGES(SS), .RESET_CYCLES(RC),
    .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .CNT_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_gt_locked(rx_gt_locked), .rx_block_lock(rx_block_lock),
    .gt_reset(gt_reset), .ctl_tx_enable(ctl_tx_enable), .ctl_rx_enable(ctl_rx_enable),
    .mac_ready(mac_ready), .retry_cnt(retry_cnt), .drop_cnt(drop_cnt),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  mac_link_sequencer #(
    .DATA_W(DW), .SYNC_STAGES(SS), .RESET_CYCLES(4),
    .LOCK_TIMEOUT(20), .STABLE_CYCLES(4), .CNT_W(24)
  ) u_sat (
    .clk(clk), .rst_n(rst_n),
    .rx_gt_locked(sat_zero), .rx_block_lock(sat_zero),
    .gt_reset(sat_gt_reset), .ctl_tx_enable(sat_tx_en), .ctl_rx_enable(sat_rx_en),
    .mac_ready(sat_ready), .retry_cnt(sat_retry), .drop_cnt(sat_drop),
    .s_axis_tdata(sat_data), .s_axis_tkeep(sat_keep),
    .s_axis_tvalid(sat_zero), .s_axis_tlast(sat_zero), .s_axis_tready(sat_s_tready),
    .m_axis_tdata(sat_m_tdata), .m_axis_tkeep(sat_m_tkeep),
    .m_axis_tvalid(sat_m_tvalid), .m_axis_tlast(sat_m_tlast), .m_axis_tready(sat_zero)
  );

  task automatic clear_stats();
    got_data.delete(); got_keep.delete(); got_last.delete();
    mv_seen = 0; s_ready_lo = 0; stall_ready_hi = 0; stall_valid_lo = 0;
  endtask

  // Drives one frame, records beats seen on m_axis, optionally stalls the MAC
  // for 10 cycles or drops the GT lock at a given beat.
  task automatic send_frame(input int nb, input logic [DW-1:0] base,
                            input int stall_at, input int gt_drop_at);
    for (int b = 0; b < nb; b++) begin
      int guard;
      bit acc;
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + DW'(b);
      s_axis_tkeep  = KW'(b) ^ 8'hA5;
      s_axis_tlast  = (b == nb - 1);
      if (b == gt_drop_at) rx_gt_locked = 1'b0;
      if (b == stall_at) begin
        m_axis_tready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          #1;
          if (s_axis_tready !== 1'b0) stall_ready_hi++;
          if (m_axis_tvalid !== 1'b1) stall_valid_lo++;
          @(negedge clk);
        end
        m_axis_tready = 1'b1;
      end
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        #1;
        if (m_axis_tvalid === 1'b1) begin
          mv_seen++;
          if (m_axis_tready) begin
            got_data.push_back(m_axis_tdata);
            got_keep.push_back(m_axis_tkeep);
            got_last.push_back(m_axis_tlast);
          end
        end
        if (s_axis_tready === 1'b1) acc = 1'b1;
        else s_ready_lo++;
        @(posedge clk);
        if (!acc) begin
          guard++;
          @(negedge clk);
        end
      end
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL send_beat_timeout: beat %0d not accepted within 50 cycles", b);
      end
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_gt_locked = 1'b0; rx_block_lock = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    m_axis_tready = 1'b1;
    sat_zero = 1'b0; sat_data = '0; sat_keep = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (gt_reset !== 1'b1) begin errors++; $display("FAIL reset_gt_reset: got %b want 1", gt_reset); end
    checks++; if ({ctl_tx_enable, ctl_rx_enable} !== 2'b00) begin errors++; $display("FAIL reset_enables: got %b want 00", {ctl_tx_enable, ctl_rx_enable}); end
    checks++; if (mac_ready !== 1'b0) begin errors++; $display("FAIL reset_mac_ready: got %b want 0", mac_ready); end
    checks++; if (retry_cnt !== 8'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    checks++; if ({s_axis_tready, m_axis_tvalid} !== 2'b10) begin errors++; $display("FAIL reset_gate: got s_tready/m_tvalid %b want 10", {s_axis_tready, m_axis_tvalid}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_retry();
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (gt_reset === 1'b1 && n < 2000);
      checks++; if (n != RC) begin errors++; $display("FAIL retry_reset_len[%0d]: got %0d want %0d", i, n, RC); end
      n = 0;
      do begin @(posedge clk); #1; n++; end while (gt_reset === 1'b0 && n < 2000);
      checks++; if (n != LT) begin errors++; $display("FAIL retry_wait_len[%0d]: got %0d want %0d", i, n, LT); end
      checks++; if (retry_cnt !== 8'(i + 1)) begin errors++; $display("FAIL retry_cnt[%0d]: got %0d want %0d", i, retry_cnt, i + 1); end
    end
  endtask

  task automatic test_drop_before_ready();
    clear_stats();
    send_frame(1, 64'h100, -1, -1);
    send_frame(4, 64'h200, -1, -1);
    send_frame(9, 64'h300, -1, -1);
    checks++; if (mv_seen != 0) begin errors++; $display("FAIL prerdy_m_tvalid: seen %0d want 0", mv_seen); end
    checks++; if (s_ready_lo != 0) begin errors++; $display("FAIL prerdy_s_tready: low %0d cycles want 0", s_ready_lo); end
    checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL prerdy_drop_cnt: got %0d want 3", drop_cnt); end
  endtask

  task automatic test_bringup();
    int n;
    logic prev_en;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({retry_cnt, drop_cnt} !== 24'd0) begin errors++; $display("FAIL bringup_async_clear: retry %0d drop %0d want 0 0", retry_cnt, drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (gt_reset === 1'b1 && n < 200);
    checks++; if (n != RC) begin errors++; $display("FAIL bringup_reset_len: got %0d want %0d", n, RC); end
    repeat (100) @(negedge clk);
    rx_gt_locked = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if ({ctl_tx_enable, mac_ready} !== 2'b00) begin errors++; $display("FAIL bringup_early: en/ready %b want 00", {ctl_tx_enable, mac_ready}); end
    rx_block_lock = 1'b1;
    n = 0; prev_en = 1'b0;
    do begin
      @(posedge clk); #1; n++;
      if (mac_ready !== 1'b1) prev_en = ctl_tx_enable;
    end while (mac_ready !== 1'b1 && n < 500);
    checks++; if (n != SS + SC + 2) begin errors++; $display("FAIL bringup_ready_latency: got %0d want %0d", n, SS + SC + 2); end
    checks++; if (prev_en !== 1'b1) begin errors++; $display("FAIL bringup_enable_lead: got %b want 1", prev_en); end
    checks++; if ({ctl_tx_enable, ctl_rx_enable, gt_reset} !== 3'b110) begin errors++; $display("FAIL bringup_outputs: got %b want 110", {ctl_tx_enable, ctl_rx_enable, gt_reset}); end
    checks++; if (retry_cnt !== 8'd0) begin errors++; $display("FAIL bringup_retry: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_backpressure();
    clear_stats();
    send_frame(6, 64'h1000, 2, -1);
    send_frame(1, 64'h2000, -1, -1);
    checks++; if (stall_ready_hi != 0) begin errors++; $display("FAIL bp_s_tready_stall: high %0d cycles want 0", stall_ready_hi); end
    checks++; if (stall_valid_lo != 0) begin errors++; $display("FAIL bp_m_tvalid_stall: low %0d cycles want 0", stall_valid_lo); end
    checks++; if (got_data.size() != 7) begin errors++; $display("FAIL bp_beat_count: got %0d want 7", got_data.size()); end
    for (int b = 0; b < 7 && b < got_data.size(); b++) begin
      logic [DW+KW:0] exp_v;
      if (b < 6) exp_v = {64'h1000 + DW'(b), KW'(b) ^ 8'hA5, b == 5};
      else       exp_v = {64'h2000, 8'hA5, 1'b1};
      checks++;
      if ({got_data[b], got_keep[b], got_last[b]} !== exp_v) begin
        errors++; $display("FAIL bp_beat[%0d]: got %h want %h", b, {got_data[b], got_keep[b], got_last[b]}, exp_v);
      end
    end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL bp_drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_glitch();
    int n, mr_hi;
    @(negedge clk);
    rx_block_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mac_ready !== 1'b1) begin errors++; $display("FAIL glitch_ready_hold: got %b want 1", mac_ready); end
    @(posedge clk);
    #1;
    checks++; if ({mac_ready, ctl_tx_enable, ctl_rx_enable, gt_reset} !== 4'b0000) begin errors++; $display("FAIL glitch_blk_loss: got %b want 0000", {mac_ready, ctl_tx_enable, ctl_rx_enable, gt_reset}); end
    repeat (5) @(negedge clk);
    rx_block_lock = 1'b1;
    mr_hi = 0;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (mac_ready !== 1'b0) mr_hi++;
    end
    rx_block_lock = 1'b0;
    @(negedge clk);
    rx_block_lock = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (mac_ready !== 1'b1 && n < 200);
    checks++; if (mr_hi != 0) begin errors++; $display("FAIL glitch_ready_early: high %0d cycles want 0", mr_hi); end
    checks++; if (n != SC + 4) begin errors++; $display("FAIL glitch_restart_latency: got %0d want %0d", n, SC + 4); end
  endtask

  task automatic test_gt_drop_mid_frame();
    clear_stats();
    send_frame(8, 64'h3000, -1, 2);
    checks++; if (got_data.size() != 8) begin errors++; $display("FAIL gtdrop_beat_count: got %0d want 8", got_data.size()); end
    for (int b = 0; b < 8 && b < got_data.size(); b++) begin
      logic [DW+KW:0] exp_v;
      exp_v = {64'h3000 + DW'(b), KW'(b) ^ 8'hA5, b == 7};
      checks++;
      if ({got_data[b], got_keep[b], got_last[b]} !== exp_v) begin
        errors++; $display("FAIL gtdrop_beat[%0d]: got %h want %h", b, {got_data[b], got_keep[b], got_last[b]}, exp_v);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({mac_ready, ctl_tx_enable} !== 2'b00) begin errors++; $display("FAIL gtdrop_not_ready: got %b want 00", {mac_ready, ctl_tx_enable}); end
    clear_stats();
    send_frame(3, 64'h4000, -1, -1);
    checks++; if (mv_seen != 0) begin errors++; $display("FAIL gtdrop_next_m_tvalid: seen %0d want 0", mv_seen); end
    checks++; if (s_ready_lo != 0) begin errors++; $display("FAIL gtdrop_next_s_tready: low %0d cycles want 0", s_ready_lo); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL gtdrop_drop_cnt: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_retry_saturation();
    int n;
    n = 0;
    while (sat_retry !== 8'd254 && n < 8000) begin @(posedge clk); #1; n++; end
    checks++; if (sat_retry !== 8'd254) begin errors++; $display("FAIL sat_reach_254: got %0d want 254", sat_retry); end
    n = 0;
    while (sat_retry !== 8'd255 && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (n != 24) begin errors++; $display("FAIL sat_last_period: got %0d want 24", n); end
    repeat (100) @(posedge clk);
    #1;
    checks++; if (sat_retry !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", sat_retry); end
  endtask

  initial begin
    test_reset();
    test_retry();
    test_drop_before_ready();
    test_bringup();
    test_backpressure();
    test_glitch();
    test_gt_drop_mid_frame();
    test_retry_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
